anton_neopixel_sequencer: RTL

ANTON_NEOPIXEL_SEQUENCER -- requirements
Module: anton_neopixel_sequencer

---
 rtl/anton_neopixel_sequencer_pkg.sv | 26 ++
 rtl/anton_neopixel_prescaler.sv | 28 ++
 rtl/anton_neopixel_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/anton_neopixel_sequencer_pkg.sv
// Shared definitions for the NeoPixel sequencer: the common header macros
// (anton_common.vh contents) plus the FSM state type and index limits.
`ifndef ANTON_COMMON_VH
`define ANTON_COMMON_VH
`define ENUM_STATE_TRANSMIT 1'b1
`define ENUM_STATE_RESET    1'b0
`define BUFFER_END_DEFAULT  63
`define CLOG2(x)            $clog2(x)
`define ENUM_FSM_IDLE       2'd0
`define ENUM_FSM_TRANSMIT   2'd1
`define ENUM_FSM_GAP        2'd2
`endif

package anton_neopixel_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = `ENUM_FSM_IDLE,
        TRANSMIT = `ENUM_FSM_TRANSMIT,
        GAP      = `ENUM_FSM_GAP
    } seqState_t;

    localparam logic [2:0] PATTERN_LAST = 3'd7;
    localparam logic [4:0] BIT_LAST     = 5'd23;
    localparam int         BYTES_PER_PIXEL_32 = 4;

endpackage

// File: rtl/anton_neopixel_prescaler.sv
// Slot prescaler: counts 0..CLK_DIV-1 while enabled, holds 0 otherwise.
// tick marks the last clk of each pattern slot.
module anton_neopixel_prescaler #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (!enable || count == COUNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = enable && (count == COUNT_LAST);

endmodule

// File: rtl/anton_neopixel_sequencer.sv
// NeoPixel frame sequencer: walks pixel/bit/slot indices through a frame, then a
// low reset gap. Optional frame counter enabled by ANTON_NEOPIXEL_FRAME_COUNT_EN.
module anton_neopixel_sequencer
    import anton_neopixel_sequencer_pkg::*;
#(
    parameter  int BUFFER_END  = `BUFFER_END_DEFAULT,
    parameter  int CLK_DIV     = 8,
    parameter  int RESET_SLOTS = 400,
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLoop,
    input  logic                   regCtrl32bit,
    input  logic [BUFFER_BITS-1:0] regLimit,
    output logic                   state,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [4:0]             pixelBitIndex,
    output logic [2:0]             bitPatternIndex,
    output logic                   frameDone,
    output logic [15:0]            frameCount
);
    localparam int GW = (RESET_SLOTS > 1) ? $clog2(RESET_SLOTS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(RESET_SLOTS - 1);
    localparam logic [BUFFER_BITS-1:0] INDEX_MAX = BUFFER_BITS'(BUFFER_END);
    localparam logic [BUFFER_BITS-1:0] STEP_32 = BUFFER_BITS'(BYTES_PER_PIXEL_32);

    seqState_t              fsm;
    logic [GW-1:0]          gapCount;
    logic                   mode32;
    logic [BUFFER_BITS-1:0] limitL;
    logic                   tick;
    logic                   prescaleEn;
    logic                   lastPixel;
    logic [BUFFER_BITS-1:0] limitClamped;

    // Dropping enable for the abort clk restarts the prescaler so the gap is full length.
    assign prescaleEn = ((fsm == TRANSMIT) && regCtrlRun) || (fsm == GAP);

    anton_neopixel_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) uPrescaler (
        .clk   (clk),
        .resetn(resetn),
        .enable(prescaleEn),
        .tick  (tick)
    );

    assign limitClamped = (regLimit > INDEX_MAX) ? INDEX_MAX : regLimit;

    // In 32-bit mode a pixel spans four bytes, so only the word index matters.
    assign lastPixel = mode32 ? ((pixelIndex >> 2) == (limitL >> 2))
                              : (pixelIndex == limitL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm             <= IDLE;
            pixelIndex      <= '0;
            pixelBitIndex   <= '0;
            bitPatternIndex <= '0;
            gapCount        <= '0;
            mode32          <= 1'b0;
            limitL          <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (regCtrlRun) begin
                        fsm             <= TRANSMIT;
                        mode32          <= regCtrl32bit;
                        limitL          <= limitClamped;
                        pixelIndex      <= '0;
                        pixelBitIndex   <= '0;
                        bitPatternIndex <= '0;
                    end
                end
                TRANSMIT: begin
                    if (!regCtrlRun) begin
                        fsm             <= GAP;
                        pixelIndex      <= '0;
                        pixelBitIndex   <= '0;
                        bitPatternIndex <= '0;
                        gapCount        <= '0;
                    end else if (tick) begin
                        if (bitPatternIndex != PATTERN_LAST) begin
                            bitPatternIndex <= bitPatternIndex + 3'd1;
                        end else begin
                            bitPatternIndex <= '0;
                            if (pixelBitIndex != BIT_LAST) begin
                                pixelBitIndex <= pixelBitIndex + 5'd1;
                            end else begin
                                pixelBitIndex <= '0;
                                if (lastPixel) begin
                                    fsm        <= GAP;
                                    pixelIndex <= '0;
                                    gapCount   <= '0;
                                end else if (mode32) begin
                                    pixelIndex <= pixelIndex + STEP_32;
                                end else begin
                                    pixelIndex <= pixelIndex + BUFFER_BITS'(1);
                                end
                            end
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gapCount == GAP_LAST) begin
                            gapCount <= '0;
                            if (regCtrlRun && regCtrlLoop) begin
                                fsm             <= TRANSMIT;
                                mode32          <= regCtrl32bit;
                                limitL          <= limitClamped;
                                pixelIndex      <= '0;
                                pixelBitIndex   <= '0;
                                bitPatternIndex <= '0;
                            end else begin
                                fsm <= IDLE;
                            end
                        end else begin
                            gapCount <= gapCount + GW'(1);
                        end
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    assign state     = (fsm == TRANSMIT) ? `ENUM_STATE_TRANSMIT : `ENUM_STATE_RESET;
    assign frameDone = (fsm == GAP) && tick && (gapCount == GAP_LAST);

`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
    logic [15:0] frameCountQ;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frameCountQ <= '0;
        end else if (frameDone) begin
            frameCountQ <= frameCountQ + 16'd1;
        end
    end

    assign frameCount = frameCountQ;
`else
    assign frameCount = '0;
`endif

endmodule
